// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM state encoding and the default boot address.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_npc_sel.sv
// Next-PC redirect selector: jr beats jump beats taken branch.
// Purely combinational; the fetch FSM decides when the result is used.
module npc_sel (
  input  logic        jr,
  input  logic        jump,
  input  logic        pc_src,
  input  logic [31:0] jr_addr,
  input  logic [31:0] pc_jump,
  input  logic [31:0] pc_branch,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    target = pc_branch;
    if (jr) begin
      target = jr_addr;
    end else if (jump) begin
      target = pc_jump;
    end
  end

  assign redirect = jr | jump | pc_src;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect
// handling with stale-response dropping, and stall hold of the delivered word.
//
// state | meaning
// IDLE  | issuing imem_req at pc_f
// WAIT  | request outstanding, response will be delivered
// VALID | instr_f/pc_f presented to decode, held while stalled
// DROP  | request outstanding, response will be discarded
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        jump,
  input  logic [31:0] pc_jump,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic        instr_valid,
  output logic        adel_f
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_nxt, instr_nxt;
  logic         valid_nxt;
  logic         redirect;
  logic [31:0]  target;

  npc_sel u_npc_sel (
    .jr        (jr),
    .jump      (jump),
    .pc_src    (pc_src),
    .jr_addr   (jr_addr),
    .pc_jump   (pc_jump),
    .pc_branch (pc_branch),
    .redirect  (redirect),
    .target    (target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc_f        <= RESET_PC;
      instr_f     <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_f        <= pc_nxt;
      instr_f     <= instr_nxt;
      instr_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_f;
    instr_nxt = instr_f;
    valid_nxt = instr_valid;
    case (state)
      IDLE: begin
        // the request already left at the old pc, so its reply must be dropped
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = DROP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && !redirect) begin
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          state_nxt = VALID;
        end else if (imem_rvalid) begin
          pc_nxt    = target;
          state_nxt = IDLE;
        end else if (redirect) begin
          pc_nxt    = target;
          state_nxt = DROP;
        end
      end
      VALID: begin
        if (!stall_f) begin
          pc_nxt    = redirect ? target : pc_f + PC_STEP;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_nxt = target;
        end
        if (imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = (state == IDLE);
  assign imem_addr = pc_f;
  assign adel_f    = instr_valid && (pc_f[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: expected requests and deliveries
// are queued by the stimulus and popped by independent monitors.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f = 1'b1;
  logic        jr = 1'b0, jump = 1'b0, pc_src = 1'b0;
  logic [31:0] jr_addr = '0, pc_jump = '0, pc_branch = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_f, instr_f;
  logic        instr_valid, adel_f;

  int total = 0;
  int bad = 0;
  int mem_lat = 1;
  logic [31:0] exp_req[$];
  logic [63:0] exp_del[$];

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .jr          (jr),
    .jr_addr     (jr_addr),
    .jump        (jump),
    .pc_jump     (pc_jump),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .instr_f     (instr_f),
    .instr_valid (instr_valid),
    .adel_f      (adel_f)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_3000) ? 32'h2408_0001 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // from VALID: one unstalled cycle, optionally with a jump redirect
  task automatic release_one(input logic do_jump, input logic [31:0] tgt);
    stall_f = 1'b0;
    jump    = do_jump;
    pc_jump = tgt;
    @(posedge clk);
    #1;
    stall_f = 1'b1;
    jump    = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    total++;
    if (!instr_valid) begin
      bad++;
      $display("FAIL %s: instr_valid=0 after %0d cycles, expected 1", name, n);
    end
  endtask

  // memory model: samples the request mid-cycle, answers mem_lat cycles later
  initial begin
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
      end else if (imem_req) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = imem_addr;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend && reset) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset && imem_req) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_req.pop_front());
        end
      end
    end
  end

  initial begin
    logic        prev_valid = 1'b0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && instr_valid && !prev_valid) begin
        if (exp_del.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: got pc %h instr %h expected none", pc_f, instr_f);
        end else begin
          e = exp_del.pop_front();
          check("del_pc", pc_f, e[63:32]);
          check("del_instr", instr_f, e[31:0]);
        end
      end
      prev_valid = reset && instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset hold and first fetch timing
    repeat (3) step();
    @(negedge clk);
    check("rst_pc", pc_f, 32'h0000_3000);
    check("rst_instr", instr_f, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_adel", 32'(adel_f), 32'd0);
    exp_req.push_back(32'h0000_3000);
    exp_del.push_back({32'h0000_3000, 32'h2408_0001});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("c1_req", 32'(imem_req), 32'd1);
    step();
    @(negedge clk);
    check("c2_valid", 32'(instr_valid), 32'd0);
    step();
    @(negedge clk);
    check("c3_valid", 32'(instr_valid), 32'd1);

    // stall holds VALID and masks a branch redirect
    pc_branch = 32'h0000_3ABC;
    for (int i = 0; i < 4; i++) begin
      step();
      pc_src = (i == 1);
      @(negedge clk);
      check("stall_instr", instr_f, 32'h2408_0001);
      check("stall_pc", pc_f, 32'h0000_3000);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    pc_src = 1'b0;
    exp_req.push_back(32'h0000_3004);
    exp_del.push_back({32'h0000_3004, mem_word(32'h0000_3004)});
    release_one(1'b0, 32'h0);
    wait_valid("b_deliver");

    // jr+jump in WAIT with slow memory: stale word dropped
    mem_lat = 3;
    exp_req.push_back(32'h0000_3008);
    exp_req.push_back(32'h0000_3100);
    exp_del.push_back({32'h0000_3100, mem_word(32'h0000_3100)});
    release_one(1'b0, 32'h0);
    step();
    jr = 1'b1; jr_addr = 32'h0000_3100;
    jump = 1'b1; pc_jump = 32'h0000_3200;
    @(negedge clk);
    check("c_wait_req", 32'(imem_req), 32'd0);
    step();
    jr = 1'b0; jump = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    check("c_drop_pc", pc_f, 32'h0000_3100);
    check("c_drop_valid", 32'(instr_valid), 32'd0);
    wait_valid("c_deliver");

    // rvalid and branch together in WAIT
    exp_req.push_back(32'h0000_3104);
    exp_req.push_back(32'h0000_3040);
    exp_del.push_back({32'h0000_3040, mem_word(32'h0000_3040)});
    release_one(1'b0, 32'h0);
    step();
    pc_src = 1'b1; pc_branch = 32'h0000_3040;
    step();
    pc_src = 1'b0;
    @(negedge clk);
    check("d_idle_req", 32'(imem_req), 32'd1);
    check("d_idle_valid", 32'(instr_valid), 32'd0);
    wait_valid("d_deliver");

    // wrap at the top of the address space, then a misaligned jump
    exp_req.push_back(32'hFFFF_FFFC);
    exp_del.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    release_one(1'b1, 32'hFFFF_FFFC);
    wait_valid("e_top");
    check("e_top_adel", 32'(adel_f), 32'd0);
    exp_req.push_back(32'h0000_0000);
    exp_del.push_back({32'h0000_0000, mem_word(32'h0000_0000)});
    release_one(1'b0, 32'h0);
    wait_valid("e_wrap");
    check("e_wrap_pc", pc_f, 32'h0000_0000);
    exp_req.push_back(32'h0000_3002);
    exp_del.push_back({32'h0000_3002, mem_word(32'h0000_3002)});
    release_one(1'b1, 32'h0000_3002);
    @(negedge clk);
    check("e_idle_adel", 32'(adel_f), 32'd0);
    wait_valid("e_mis");
    check("e_mis_adel", 32'(adel_f), 32'd1);

    // reset while a request is outstanding
    mem_lat = 3;
    exp_req.push_back(32'h0000_3006);
    release_one(1'b0, 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("f_pc", pc_f, 32'h0000_3000);
    check("f_instr", instr_f, 32'h0);
    check("f_valid", 32'(instr_valid), 32'd0);
    check("f_adel", 32'(adel_f), 32'd0);
    check("f_req", 32'(imem_req), 32'd1);
    mem_lat = 1;
    repeat (2) step();
    exp_req.push_back(32'h0000_3000);
    exp_del.push_back({32'h0000_3000, 32'h2408_0001});
    reset = 1'b1;
    wait_valid("f_restart");

    repeat (3) step();
    check("queue_left", 32'(exp_req.size() + exp_del.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
